// File: rtl/data_register_file_sb.sv
// Register file with two registered read ports, write-to-read bypass, optional
// hardwired zero register and a per-register busy scoreboard for pending writebacks.
module data_register_file_sb #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int ZERO_REGISTER = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     reserve_enable,
  input  logic [ADDRESS_WIDTH-1:0] reserve_address,
  input  logic                     read_enable,
  input  logic [ADDRESS_WIDTH-1:0] read_address_1,
  input  logic [ADDRESS_WIDTH-1:0] read_address_2,
  output logic [DATA_WIDTH-1:0]    read_data_1,
  output logic [DATA_WIDTH-1:0]    read_data_2,
  output logic                     busy_1,
  output logic                     busy_2
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic [DATA_WIDTH-1:0] read_data_1_q;
  logic [DATA_WIDTH-1:0] read_data_1_d;
  logic [DATA_WIDTH-1:0] read_data_2_q;
  logic [DATA_WIDTH-1:0] read_data_2_d;
  logic                  busy_1_q;
  logic                  busy_1_d;
  logic                  busy_2_q;
  logic                  busy_2_d;
  logic                  wr_ok_s;
  logic                  rsv_ok_s;

  // Register 0 never changes when hardwired, so it always reads 0 and never busy.
  assign wr_ok_s  = write_enable &&
                    !((ZERO_REGISTER != 0) && (write_address == {ADDRESS_WIDTH{1'b0}}));
  assign rsv_ok_s = reserve_enable &&
                    !((ZERO_REGISTER != 0) && (reserve_address == {ADDRESS_WIDTH{1'b0}}));

  // Post-edge busy state; a same-cycle reserve beats the clearing write.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      busy_d[i] = (rsv_ok_s && (reserve_address == ADDRESS_WIDTH'(i))) ? 1'b1 :
                  (wr_ok_s  && (write_address   == ADDRESS_WIDTH'(i))) ? 1'b0 :
                  busy_q[i];
    end
  end

  // Next read-port values, with the write bypass.
  always_comb begin
    read_data_1_d = (wr_ok_s && (write_address == read_address_1)) ? write_data
                                                                     : regs_q[read_address_1];
    read_data_2_d = (wr_ok_s && (write_address == read_address_2)) ? write_data
                                                                     : regs_q[read_address_2];
    busy_1_d      = busy_d[read_address_1];
    busy_2_d      = busy_d[read_address_2];
  end

  // Register array.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_q[write_address] <= write_data;
    end
  end

  // Scoreboard bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= {DEPTH{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  // Read-port output registers hold while read_enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_1_q <= {DATA_WIDTH{1'b0}};
      read_data_2_q <= {DATA_WIDTH{1'b0}};
      busy_1_q      <= 1'b0;
      busy_2_q      <= 1'b0;
    end else if (read_enable) begin
      read_data_1_q <= read_data_1_d;
      read_data_2_q <= read_data_2_d;
      busy_1_q      <= busy_1_d;
      busy_2_q      <= busy_2_d;
    end
  end

  assign read_data_1 = read_data_1_q;
  assign read_data_2 = read_data_2_q;
  assign busy_1      = busy_1_q;
  assign busy_2      = busy_2_q;

endmodule
